// File: rtl/gerador_pulso_if.sv
// gerador_pulso_if -- signal bundle for the gerador_pulso multi-channel pulse
// generator.
//
// Signals (one bit per channel unless noted):
//   evento   : per-channel event strobe, one-cycle pulse per event
//   limpa    : synchronous clear of every perdido flag (1 bit)
//   saida    : per-channel registered pulse output
//   perdido  : per-channel sticky "event dropped" flag
//   contagem : saturating count of accepted events, all channels (8 bits)
//
// Modports:
//   master : event source / status reader (drives evento, limpa)
//   slave  : the pulse generator itself
interface gerador_pulso_if #(
   parameter int CANAIS = 2
);
   logic [CANAIS-1:0] evento;
   logic              limpa;
   logic [CANAIS-1:0] saida;
   logic [CANAIS-1:0] perdido;
   logic [7:0]        contagem;

   modport master (
      output evento,
      output limpa,
      input  saida,
      input  perdido,
      input  contagem
   );

   modport slave (
      input  evento,
      input  limpa,
      output saida,
      output perdido,
      output contagem
   );
endinterface

// File: rtl/gerador_pulso.sv
// gerador_pulso -- multi-channel fixed-width pulse generator.
//
// Each channel turns a one-cycle event strobe into a LARGURA-cycle high level
// on saida. A per-channel 8-bit down-counter times the pulse; the counter is
// loaded with LARGURA on an accepted event and counts down to zero.
//
// Parameters:
//   LARGURA : pulse width in clk cycles (1..255)
//   CANAIS  : number of independent channels (1..8)
//
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous, active-high reset
//   bus : gerador_pulso_if.slave -- evento/limpa in, saida/perdido/contagem out
//
// Build option:
//   GERADOR_PULSO_RETRIGGER_EN defined   : an event on an active channel
//                                          reloads the counter (pulse stretch);
//                                          perdido is tied to 0.
//   GERADOR_PULSO_RETRIGGER_EN undefined : an event on an active channel is
//                                          dropped and flagged in perdido.
//
// Per-channel states:
//   state  | meaning
//   -------+--------------------------------------------
//   OCIOSO | cnt = 0, saida low, next event always accepted
//   ATIVO  | cnt > 0, saida high, counting down to zero
module gerador_pulso #(
   parameter int LARGURA = 4,
   parameter int CANAIS  = 2
) (
   input  logic            clk,
   input  logic            rst,
   gerador_pulso_if.slave  bus
);

   typedef enum logic {
      OCIOSO = 1'b0,
      ATIVO  = 1'b1
   } estado_t;

   localparam logic [7:0] CARGA = 8'(LARGURA);

   estado_t           estado_q [CANAIS];
   estado_t           estado_d [CANAIS];
   logic [7:0]        cnt_q    [CANAIS];
   logic [7:0]        cnt_d    [CANAIS];
   logic [CANAIS-1:0] aceito;
   logic [3:0]        n_aceitos;
   logic [8:0]        soma;
   logic [7:0]        contagem_q;
   logic [7:0]        contagem_d;

`ifndef GERADOR_PULSO_RETRIGGER_EN
   logic [CANAIS-1:0] perda;
   logic [CANAIS-1:0] perdido_q;
   logic [CANAIS-1:0] perdido_d;
`else
   logic              unused_limpa;
   assign unused_limpa = bus.limpa;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CANAIS; i++) begin
            estado_q[i] <= OCIOSO;
            cnt_q[i]    <= 8'd0;
         end
         contagem_q <= 8'd0;
`ifndef GERADOR_PULSO_RETRIGGER_EN
         perdido_q  <= '0;
`endif
      end else begin
         for (int i = 0; i < CANAIS; i++) begin
            estado_q[i] <= estado_d[i];
            cnt_q[i]    <= cnt_d[i];
         end
         contagem_q <= contagem_d;
`ifndef GERADOR_PULSO_RETRIGGER_EN
         perdido_q  <= perdido_d;
`endif
      end
   end

   always_comb begin
      aceito    = '0;
      n_aceitos = 4'd0;
`ifndef GERADOR_PULSO_RETRIGGER_EN
      perda     = '0;
`endif
      for (int i = 0; i < CANAIS; i++) begin
         cnt_d[i]    = cnt_q[i];
         estado_d[i] = estado_q[i];
         case (estado_q[i])
            OCIOSO: begin
               if (bus.evento[i]) begin
                  aceito[i] = 1'b1;
                  cnt_d[i]  = CARGA;
               end
            end
            ATIVO: begin
               if (bus.evento[i]) begin
`ifdef GERADOR_PULSO_RETRIGGER_EN
                  aceito[i] = 1'b1;
                  cnt_d[i]  = CARGA;
`else
                  // Dropped event leaves the running pulse untouched.
                  perda[i]  = 1'b1;
                  cnt_d[i]  = cnt_q[i] - 8'd1;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] - 8'd1;
               end
            end
            default: begin
               cnt_d[i] = 8'd0;
            end
         endcase
         // State tracks the next counter value so saida is a pure register.
         estado_d[i] = (cnt_d[i] != 8'd0) ? ATIVO : OCIOSO;
         n_aceitos   = n_aceitos + {3'b000, aceito[i]};
      end

      soma       = {1'b0, contagem_q} + {5'b00000, n_aceitos};
      contagem_d = soma[8] ? 8'hFF : soma[7:0];

`ifndef GERADOR_PULSO_RETRIGGER_EN
      // A drop in the same cycle as limpa wins, so no event goes unreported.
      perdido_d = (perdido_q & ~{CANAIS{bus.limpa}}) | perda;
`endif
   end

   always_comb begin
      bus.saida = '0;
      for (int i = 0; i < CANAIS; i++) begin
         bus.saida[i] = (estado_q[i] == ATIVO);
      end
   end

   assign bus.contagem = contagem_q;
`ifdef GERADOR_PULSO_RETRIGGER_EN
   assign bus.perdido  = '0;
`else
   assign bus.perdido  = perdido_q;
`endif

endmodule

// File: tb/tb_gerador_pulso.sv
// tb_gerador_pulso -- directed bench for gerador_pulso.
// dut_a: LARGURA=4, CANAIS=2 (vector table, reset cases)
// dut_b: LARGURA=1, CANAIS=2 (single-cycle pulses, held strobe, saturation)
module tb_gerador_pulso;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   gerador_pulso_if #(.CANAIS(2)) bus_a ();
   gerador_pulso_if #(.CANAIS(2)) bus_b ();

   gerador_pulso #(.LARGURA(4), .CANAIS(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   gerador_pulso #(.LARGURA(1), .CANAIS(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] ev;
      logic       limpa;
      logic [1:0] sai;
      logic [1:0] per;
      logic [7:0] cnt;
   } vec_t;

   vec_t tab [19];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nome, got, exp);
      end
   endtask

   initial begin
      logic [7:0] prev;
      logic       wrapped;
      int         exp_c;

      n_tests = 0;
      n_fail  = 0;

`ifdef GERADOR_PULSO_RETRIGGER_EN
      tab[0]  = '{2'b00, 1'b0, 2'b00, 2'b00, 8'd0};
      tab[1]  = '{2'b01, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[2]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[3]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[4]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[5]  = '{2'b00, 1'b0, 2'b00, 2'b00, 8'd1};
      tab[6]  = '{2'b01, 1'b0, 2'b01, 2'b00, 8'd2};
      tab[7]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd2};
      tab[8]  = '{2'b01, 1'b0, 2'b01, 2'b00, 8'd3};
      tab[9]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd3};
      tab[10] = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd3};
      tab[11] = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd3};
      tab[12] = '{2'b00, 1'b0, 2'b00, 2'b00, 8'd3};
      tab[13] = '{2'b11, 1'b0, 2'b11, 2'b00, 8'd5};
      tab[14] = '{2'b00, 1'b1, 2'b11, 2'b00, 8'd5};
      tab[15] = '{2'b00, 1'b0, 2'b11, 2'b00, 8'd5};
      tab[16] = '{2'b10, 1'b0, 2'b11, 2'b00, 8'd6};
      tab[17] = '{2'b01, 1'b1, 2'b11, 2'b00, 8'd7};
      tab[18] = '{2'b00, 1'b0, 2'b11, 2'b00, 8'd7};
`else
      tab[0]  = '{2'b00, 1'b0, 2'b00, 2'b00, 8'd0};
      tab[1]  = '{2'b01, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[2]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[3]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[4]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd1};
      tab[5]  = '{2'b00, 1'b0, 2'b00, 2'b00, 8'd1};
      tab[6]  = '{2'b01, 1'b0, 2'b01, 2'b00, 8'd2};
      tab[7]  = '{2'b00, 1'b0, 2'b01, 2'b00, 8'd2};
      tab[8]  = '{2'b01, 1'b0, 2'b01, 2'b01, 8'd2};
      tab[9]  = '{2'b00, 1'b0, 2'b01, 2'b01, 8'd2};
      tab[10] = '{2'b00, 1'b0, 2'b00, 2'b01, 8'd2};
      tab[11] = '{2'b11, 1'b0, 2'b11, 2'b01, 8'd4};
      tab[12] = '{2'b00, 1'b1, 2'b11, 2'b00, 8'd4};
      tab[13] = '{2'b00, 1'b0, 2'b11, 2'b00, 8'd4};
      tab[14] = '{2'b10, 1'b0, 2'b11, 2'b10, 8'd4};
      tab[15] = '{2'b01, 1'b1, 2'b00, 2'b01, 8'd4};
      tab[16] = '{2'b00, 1'b0, 2'b00, 2'b01, 8'd4};
      tab[17] = '{2'b00, 1'b0, 2'b00, 2'b01, 8'd4};
      tab[18] = '{2'b00, 1'b1, 2'b00, 2'b00, 8'd4};
`endif

      rst          = 1'b1;
      bus_a.evento = 2'b00;
      bus_a.limpa  = 1'b0;
      bus_b.evento = 2'b00;
      bus_b.limpa  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("reset saida_a",    bus_a.saida,    2'b00);
      chk("reset perdido_a",  bus_a.perdido,  2'b00);
      chk("reset contagem_a", bus_a.contagem, 8'd0);
      chk("reset saida_b",    bus_b.saida,    2'b00);

      // Vector table on dut_a (LARGURA=4).
      for (int i = 0; i < 19; i++) begin
         bus_a.evento = tab[i].ev;
         bus_a.limpa  = tab[i].limpa;
         tick();
         chk($sformatf("vec%0d saida", i),    bus_a.saida,    tab[i].sai);
         chk($sformatf("vec%0d perdido", i),  bus_a.perdido,  tab[i].per);
         chk($sformatf("vec%0d contagem", i), bus_a.contagem, tab[i].cnt);
      end
      bus_a.evento = 2'b00;
      bus_a.limpa  = 1'b0;
      repeat (6) tick();

      // Reset asserted between edges in the middle of a pulse.
      bus_a.evento = 2'b01;
      tick();
      tick();
      bus_a.evento = 2'b00;
      chk("pre-rst saida_a", bus_a.saida, 2'b01);
`ifndef GERADOR_PULSO_RETRIGGER_EN
      chk("pre-rst perdido_a", bus_a.perdido, 2'b01);
`endif
      #3;
      rst = 1'b1;
      #1;
      chk("async rst saida_a",    bus_a.saida,    2'b00);
      chk("async rst perdido_a",  bus_a.perdido,  2'b00);
      chk("async rst contagem_a", bus_a.contagem, 8'd0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("post-rst idle%0d saida_a", i), bus_a.saida, 2'b00);
      end

      // Event at the very first edge after reset release.
      #3;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      bus_a.evento = 2'b01;
      tick();
      bus_a.evento = 2'b00;
      chk("first edge saida_a",    bus_a.saida,    2'b01);
      chk("first edge contagem_a", bus_a.contagem, 8'd1);

      // LARGURA=1, strobe held high for 6 cycles on channel 1.
      for (int i = 0; i < 6; i++) begin
         bus_b.evento = 2'b10;
         tick();
`ifdef GERADOR_PULSO_RETRIGGER_EN
         chk($sformatf("held%0d saida_b", i), bus_b.saida, 2'b10);
`else
         chk($sformatf("held%0d saida_b", i), bus_b.saida, (i % 2 == 0) ? 2'b10 : 2'b00);
`endif
      end
      bus_b.evento = 2'b00;
      tick();
      chk("held end saida_b", bus_b.saida, 2'b00);
`ifdef GERADOR_PULSO_RETRIGGER_EN
      chk("held perdido_b",  bus_b.perdido,  2'b00);
      chk("held contagem_b", bus_b.contagem, 8'd6);
      exp_c = 6;
`else
      chk("held perdido_b",  bus_b.perdido,  2'b10);
      chk("held contagem_b", bus_b.contagem, 8'd3);
      exp_c = 3;
`endif

      // LARGURA=1, isolated event: exactly one high cycle.
      bus_b.evento = 2'b01;
      tick();
      bus_b.evento = 2'b00;
      chk("single saida_b hi", bus_b.saida, 2'b01);
      tick();
      chk("single saida_b lo", bus_b.saida, 2'b00);
      chk("single contagem_b", bus_b.contagem, exp_c + 1);

      // Saturation: 300 isolated events on dut_b channel 0.
      #3;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      prev    = 8'd0;
      wrapped = 1'b0;
      for (int j = 1; j <= 300; j++) begin
         bus_b.evento = 2'b01;
         tick();
         bus_b.evento = 2'b00;
         tick();
         if (bus_b.contagem < prev) wrapped = 1'b1;
         prev = bus_b.contagem;
         if (j == 1 || j == 254 || j == 255 || j == 256 || j == 300)
            chk($sformatf("sat ev%0d contagem_b", j), bus_b.contagem, (j > 255) ? 255 : j);
      end
      chk("sat no wrap", wrapped, 1'b0);
      chk("sat saida_b idle", bus_b.saida, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gerador_pulso.md
GERADOR_PULSO -- requirements
Module: gerador_pulso

Interface
REQ-001 Parameter LARGURA, default 4, output pulse width in clk cycles; legal range 1..255.
REQ-002 Parameter CANAIS, default 2, number of independent channels; legal range 1..8.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 evento  input  CANAIS  per-channel event strobe; one-cycle pulse per event (rising-edge detector output format).
REQ-006 limpa  input  1  synchronous clear of all perdido flags.
REQ-007 saida  output  CANAIS  per-channel registered level output, high for LARGURA cycles per accepted event.
REQ-008 perdido  output  CANAIS  per-channel sticky flag: an event was dropped.
REQ-009 contagem  output  8  saturating count of accepted events, all channels summed.

Function
REQ-010 Each channel SHALL hold an 8-bit down-counter cnt[i]; saida[i] SHALL equal (cnt[i] != 0), registered.
REQ-011 Each channel SHALL have two states: OCIOSO (cnt=0, saida low) and ATIVO (cnt>0, saida high).
REQ-012 An accepted event sampled high at edge k SHALL load cnt[i]=LARGURA, so saida[i] is high from edge k through edge k+LARGURA-1, low from edge k+LARGURA, unless retriggered (latency: 1 cycle).
REQ-013 In ATIVO with no accepted event, cnt[i] SHALL decrement by 1 per cycle; ATIVO->OCIOSO when cnt reaches 0.
REQ-014 An event while OCIOSO SHALL always be accepted.
REQ-015 Handling of an event while ATIVO (including the final high cycle, cnt=1) SHALL be defined by REQ-024/REQ-025.
REQ-016 perdido[i] SHALL set on a dropped event and hold until limpa or rst; if limpa and a drop occur in the same cycle, perdido[i] SHALL end set.
REQ-017 contagem SHALL increment by the number of events accepted in that cycle (0..CANAIS) and saturate at 255, never wrap.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled per REQ-012..REQ-016.
REQ-019 With LARGURA=1, each accepted event SHALL produce exactly one high cycle on saida[i].

Reset
REQ-020 On rst assertion, saida, perdido, contagem and all cnt SHALL clear to 0 immediately, without waiting for clk.
REQ-021 Reset mid-pulse SHALL abort the pulse; no residual high cycle after rst deasserts.
REQ-022 An event sampled at the first edge after rst deasserts SHALL be accepted normally.

Configuration
REQ-023 Macro GERADOR_PULSO_RETRIGGER_EN SHALL select retrigger behaviour.
REQ-024 Defined: an event while ATIVO SHALL be accepted and reload cnt[i]=LARGURA, extending the pulse; perdido never sets and SHALL read constant 0.
REQ-025 Undefined: an event while ATIVO SHALL be dropped, cnt[i] unaffected, perdido[i] set, contagem not incremented.

Verification
REQ-026 LARGURA=4, evento[0] pulse at edge 10 -> saida[0] high edges 10..13, low at 14; contagem=1; saida[1] stays 0.
REQ-027 LARGURA=4, evento[0] pulses at edges 10 and 12 -> with macro: saida[0] high 10..15, contagem=2, perdido=0; without: high 10..13, perdido[0]=1, contagem=1.
REQ-028 LARGURA=1, evento[1] held high 6 cycles -> with macro: saida[1] high 6 cycles; without: pattern 1,0,1,0,1,0, perdido[1]=1, contagem=3.
REQ-029 Both channels pulsed same edge, then limpa pulse -> contagem increments by 2; perdido cleared to 0 one cycle after limpa.
REQ-030 rst asserted mid-pulse between clock edges -> saida, perdido, contagem read 0 before next edge; no high after release.
REQ-031 300 isolated events on channel 0 -> contagem saturates at 255, no wrap.
